// File: rtl/sync_reset_seq.sv
// rtl/sync_reset_seq.sv - sequenced per-channel reset release with synchronised software request (DFT bypass macro: SYNC_RESET_SEQ_TEST_MODE_EN)
module sync_reset_seq #(
    parameter int NUM_CH     = 4,
    parameter int SYNC_DEPTH = 2,
    parameter int STRETCH    = 8,
    parameter int STEP       = 4
) (
    input  logic              clk,
    input  logic              inreset,
    input  logic              sw_req,
    input  logic              test_mode,
    input  logic              direct_reset_,
    output logic [NUM_CH-1:0] outreset_,
    output logic              busy,
    output logic              done
);

    localparam int CNT_MAX = (STRETCH > STEP) ? STRETCH : STEP;
    localparam int CW      = $clog2(CNT_MAX + 1);

    // The counter restarts at zero on each wait, so a wait of N cycles ends when it reads N-1
    localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH - 1);
    localparam logic [CW-1:0] STEP_LAST    = CW'(STEP - 1);

    typedef enum logic [1:0] {
        ASSERT,
        STRETCH_WAIT,
        RELEASE,
        DONE
    } state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [NUM_CH-1:0]       fsm_rst_;
    logic [NUM_CH-1:0]       next_rst_;
    logic [SYNC_DEPTH-1:0]   sync_ff;
    logic                    sw_sync;
    logic                    at_limit;

    assign sw_sync = sync_ff[SYNC_DEPTH-1];

    // Releasing one more channel shifts a 1 in from bit 0, so bit 0 always goes first
    assign next_rst_ = (fsm_rst_ << 1) | NUM_CH'(1);

    assign at_limit = (state == STRETCH_WAIT) ? (cnt == STRETCH_LAST) : (cnt == STEP_LAST);

    // Synchroniser chain for the foreign-domain software request
    always_ff @(posedge clk) begin
        if (inreset) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_DEPTH-2:0], sw_req};
        end
    end

    // Sequencer: hold all channels, stretch, then release one channel per step
    always_ff @(posedge clk) begin
        if (inreset || sw_sync) begin
            state    <= ASSERT;
            cnt      <= '0;
            fsm_rst_ <= '0;
            done     <= 1'b0;
            busy     <= 1'b1;
        end else begin
            case (state)
                ASSERT: begin
                    cnt      <= '0;
                    fsm_rst_ <= '0;
                    state    <= STRETCH_WAIT;
                end
                STRETCH_WAIT, RELEASE: begin
                    if (at_limit) begin
                        cnt      <= '0;
                        fsm_rst_ <= next_rst_;
                        if (&next_rst_) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= RELEASE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    cnt <= '0;
                end
                default: begin
                    state <= ASSERT;
                end
            endcase
        end
    end

`ifdef SYNC_RESET_SEQ_TEST_MODE_EN
    assign outreset_ = test_mode ? {NUM_CH{direct_reset_}} : fsm_rst_;
`else
    logic unused_dft;
    assign unused_dft = test_mode ^ direct_reset_;
    assign outreset_  = fsm_rst_;
`endif

endmodule

// File: doc/sync_reset_seq.md
SYNC_RESET_SEQ -- requirements
Module: sync_reset_seq

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of sequenced reset outputs (legal 1..32).
REQ-002 SHALL have parameter SYNC_DEPTH, default 2, flop stages on sw_req (legal 2..4).
REQ-003 SHALL have parameter STRETCH, default 8, minimum all-asserted cycles before first release (legal 1..255).
REQ-004 SHALL have parameter STEP, default 4, cycles between consecutive channel releases (legal 1..255).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port inreset, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have port sw_req, input, 1, asynchronous software reset request level from a foreign domain.
REQ-008 SHALL have port test_mode, input, 1, DFT mode select.
REQ-009 SHALL have port direct_reset_, input, 1, DFT direct active-low reset.
REQ-010 SHALL have port outreset_, output, NUM_CH, per-channel active-low reset, bit 0 released first.
REQ-011 SHALL have port busy, output, 1, high while any channel is held in reset.
REQ-012 SHALL have port done, output, 1, high once all channels are released.

Function
REQ-013 SHALL pass sw_req through SYNC_DEPTH flops; only the last stage (sw_sync) feeds logic.
REQ-014 SHALL implement FSM states ASSERT, STRETCH_WAIT, RELEASE, DONE with one counter of width clog2(max(STRETCH,STEP)+1).
REQ-015 SHALL, in ASSERT, drive outreset_ all-zero, clear the counter, and move to STRETCH_WAIT on the first edge at which inreset=0 and sw_sync=0.
REQ-016 SHALL, defining edge 0 as the first edge with inreset=0 and sw_sync=0, raise outreset_[i] at edge STRETCH+i*STEP, releasing exactly one new channel per release edge.
REQ-017 SHALL keep every released channel high until the next ASSERT entry, never re-asserting a single channel alone.
REQ-018 SHALL enter DONE on the edge the last channel releases; done=1 and busy=0 from that edge.
REQ-019 SHALL, with NUM_CH=1, pass directly from STRETCH_WAIT to DONE at edge STRETCH.
REQ-020 SHALL, on any edge with sw_sync=1 in any state, enter ASSERT: outreset_ all-zero, done=0, busy=1 and counter cleared on that edge.
REQ-021 SHALL hold ASSERT as long as sw_sync=1; sequencing restarts from edge 0 after it falls.
REQ-022 SHALL give sw_req-high-to-outreset_-low latency of SYNC_DEPTH+1 edges; sw_req pulses shorter than one clk period need not be captured.
REQ-023 SHALL keep busy = ~done at every cycle.

Reset
REQ-024 SHALL, on any edge with inreset=1, set state ASSERT, counter 0, all synchroniser flops 0, outreset_ all-zero, done=0, busy=1.
REQ-025 SHALL treat inreset asserted mid-sequence identically to REQ-024, abandoning partial release.

Configuration
REQ-026 SHALL use macro SYNC_RESET_SEQ_TEST_MODE_EN to gate DFT bypass.
REQ-027 SHALL, with macro defined and test_mode=1, drive every outreset_ bit combinationally from direct_reset_, FSM continuing unobserved; test_mode=0 selects the FSM outputs.
REQ-028 SHALL, with macro undefined, retain test_mode and direct_reset_ ports but ignore them; outreset_ comes only from FSM registers.

Verification
REQ-029 SHALL cover default parameters, inreset high 3 cycles then low -> outreset_ 0000 until edge 8, then 0001@8, 0011@12, 0111@16, 1111@20, done=1@20.
REQ-030 SHALL cover sw_req raised at edge 30 while in DONE (SYNC_DEPTH=2) -> outreset_=0000, done=0 at edge 33; release 0001 at 8 edges after sw_sync falls.
REQ-031 SHALL cover inreset pulsed one cycle at edge 14 (outreset_=0011) -> outreset_=0000 at edge 14, full sequence restarts from edge 15 as edge 0.
REQ-032 SHALL cover NUM_CH=1, STRETCH=1, STEP=1 -> outreset_=1 and done=1 one edge after inreset falls.
REQ-033 SHALL cover macro defined, test_mode=1, direct_reset_ toggled 0/1 during release -> all outreset_ bits follow direct_reset_ same cycle; test_mode=0 restores FSM value.
REQ-034 SHALL cover macro undefined, test_mode=1, direct_reset_=0 -> outreset_ sequence identical to REQ-029.
